// File: rtl/pwm_deadtime_if.sv
// Bundles the pwm_deadtime control inputs and drive outputs.
// master: the side that supplies pwm/enable/dead time and observes the drives.
// slave:  the dead-time generator itself.
interface pwm_deadtime_if #(
  parameter int DT_WIDTH = 8
);
  logic                out_en;
  logic                pwm_in;
  logic [DT_WIDTH-1:0] dead_time;
  logic                pwm_h;
  logic                pwm_l;
  logic                dt_active;

  modport master (
    output out_en,
    output pwm_in,
    output dead_time,
    input  pwm_h,
    input  pwm_l,
    input  dt_active
  );

  modport slave (
    input  out_en,
    input  pwm_in,
    input  dead_time,
    output pwm_h,
    output pwm_l,
    output dt_active
  );
endinterface

// File: rtl/pwm_deadtime.sv
// Complementary half-bridge drive with programmable dead time.
// pwm_in is registered once; every decision uses the registered copy, and
// all outputs are decodes of the state register so nothing combinational
// reaches the gate drivers from pwm_in.
module pwm_deadtime #(
  parameter int DT_WIDTH = 8
) (
  input logic           chosen_clk,
  input logic           rst_n,
  pwm_deadtime_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOW_ON  = 3'd1,
    HIGH_ON = 3'd2,
    DEAD_LH = 3'd3,
    DEAD_HL = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [DT_WIDTH-1:0] cnt_q, cnt_d;
  logic                pwm_r_q, pwm_r_d;

  logic                dt_zero;
  logic [DT_WIDTH-1:0] dt_load;

  // dead_time is only consumed here, on entry to a dead state; a later
  // change cannot disturb a gap that is already counting down.
  assign dt_zero = (bus.dead_time == '0);
  assign dt_load = bus.dead_time - DT_WIDTH'(1);

  // Next-state, counter and input-sync logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pwm_r_d = bus.pwm_in;

    if (!bus.out_en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (dt_zero) begin
            state_d = pwm_r_q ? HIGH_ON : LOW_ON;
          end else begin
            state_d = pwm_r_q ? DEAD_LH : DEAD_HL;
            cnt_d   = dt_load;
          end
        end
        LOW_ON: begin
          if (pwm_r_q) begin
            if (dt_zero) begin
              state_d = HIGH_ON;
            end else begin
              state_d = DEAD_LH;
              cnt_d   = dt_load;
            end
          end
        end
        HIGH_ON: begin
          if (!pwm_r_q) begin
            if (dt_zero) begin
              state_d = LOW_ON;
            end else begin
              state_d = DEAD_HL;
              cnt_d   = dt_load;
            end
          end
        end
        DEAD_LH: begin
          // Pulse ended before the gap did: the high side is never driven.
          if (!pwm_r_q)          state_d = LOW_ON;
          else if (cnt_q == '0)  state_d = HIGH_ON;
          else                   cnt_d   = cnt_q - DT_WIDTH'(1);
        end
        DEAD_HL: begin
          if (pwm_r_q)           state_d = HIGH_ON;
          else if (cnt_q == '0)  state_d = LOW_ON;
          else                   cnt_d   = cnt_q - DT_WIDTH'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, counter and synchronised pwm register with synchronous reset.
  always_ff @(posedge chosen_clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pwm_r_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pwm_r_q <= pwm_r_d;
    end
  end

  assign bus.pwm_h     = (state_q == HIGH_ON);
  assign bus.pwm_l     = (state_q == LOW_ON);
  assign bus.dt_active = (state_q == DEAD_LH) || (state_q == DEAD_HL);

endmodule
